instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-memory responder at the consuming end of the program-counter interface. It owns the 2**IMW-word instruction store, accepts a program image through a streaming load port, then answers every program-counter address with a registered instruction word. At the end of a load it emits the single-cycle `start` pulse that initialises the program counter, and it supports flush and reload.

## Interface
- `IW`, 8, instruction word width in bits
- `IMW`, 4, instruction address width; store depth = 2**IMW words

- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `load_valid`  in  1  load beat offered
- `load_ready`  out  1  load beat can be accepted
- `load_data`  in  IW  instruction word for current load address
- `load_last`  in  1  qualifies the final beat of an image (sampled only with an accepted beat)
- `load_restart`  in  1  abandon RUN and begin a new load at address 0
- `start`  out  1  one-cycle pulse when a load completes; drives the program counter's start input
- `pc_in`  in  IMW  fetch address from the program counter
- `flush`  in  1  squash the fetch sampled this cycle (branch redirect)
- `instr`  out  IW  fetched instruction
- `instr_valid`  out  1  `instr` holds a live fetch
- `parity_err`  out  1  parity mismatch on the current `instr` (see Configuration)

## Operation
- State machine with two states, LOAD and RUN. Reset enters LOAD.
- LOAD:
  - `load_ready`=1.
  - A beat is accepted when `load_valid && load_ready`. It writes `load_data` to `mem[waddr]`, then `waddr` increments modulo 2**IMW.
  - Leave for RUN when the accepted beat has `load_last`=1, or when it writes address 2**IMW-1 (wrap). After the wrap, `waddr`=0.
  - Words not written in this load keep their previous contents.
- RUN:
  - `load_ready`=0. `load_valid` is ignored.
  - Every cycle, `instr` <= `mem[pc_in]` and `instr_valid` <= `!flush`.
  - `load_restart`=1 returns to LOAD with `waddr`=0 and `instr_valid` <= 0. Restart has priority over `flush` and over the fetch.
- `start` is registered: it is high for exactly the one cycle after the edge that accepted the final beat.
- Reset values:
  - state=LOAD, `waddr`=0.
  - `load_ready`=1, `start`=0, `instr_valid`=0, `instr`=0, `parity_err`=0.
  - Memory contents are not reset.
- Reset mid-load discards progress: `waddr` returns to 0, and words already written stay written.

## Timing
- Fetch latency is 1 cycle: `pc_in` sampled at edge K appears on `instr` and `instr_valid` after edge K.
- Final load beat accepted at edge N:
  - State=RUN and `start`=1 from edge N to N+1.
  - The first fetch is sampled at edge N+1.
  - `instr_valid` can first be high after edge N+1.
- `flush` at edge K forces `instr_valid`=0 for the cycle after K only. The next non-flushed cycle resumes with no extra bubble.
- `load_restart` at edge K:
  - `load_ready`=1 after K.
  - The first new beat can be accepted at edge K+1.
- `load_ready` depends only on state, with no combinational path from `load_valid`.
- Write-then-read of the same address cannot occur, because the two happen in disjoint states.

## Configuration
- Macro `IFETCH_PARITY_EN`.
- Defined:
  - Each stored word carries one extra even-parity bit, computed at load time.
  - On every RUN fetch, `parity_err` <= parity mismatch of the read word. It is 0 when the fetch is flushed.
  - `instr_valid` is unaffected by parity.
- Undefined:
  - The store is IW bits wide.
  - `parity_err` is tied to 0.
  - No parity logic is instantiated.

## Structure
- Shared package `glorb_pkg` holds:
  - the default `IW`/`IMW` constants;
  - the state enum {LOAD, RUN};
  - the parity-bit width constant (0 or 1, selected by the macro).
- Sub-module `imem_bank` contains:
  - a 2**IMW × (IW+parity) array;
  - a synchronous write port;
  - a registered read port.
- `instr_fetch` contains the FSM, address counter, start pulse, flush and parity check.

## Test plan
- Full-image load: reset, stream 16 beats of 0x10+i with `load_last`=0 -> the wrap ends the load; `start` is high exactly one cycle; `load_ready`=0 afterwards.
- Fetch: after the full load, `pc_in`=5 -> next cycle `instr`=0x15, `instr_valid`=1; `pc_in`=15 then 0 -> 0x1F then 0x10 on consecutive cycles.
- Partial load: full image of 0x10+i, then `load_restart`, then 3 beats 0xA0..0xA2 with `load_last` on the third -> `start` pulses; fetch of address 2 returns 0xA2 and fetch of address 3 returns 0x13.
- Flush: in RUN with `pc_in`=4, hold `flush` for one cycle -> `instr_valid`=0 the next cycle, then 1 with `instr`=0x14.
- Reset mid-load: after 7 accepted beats, `rst_n`=0 for one cycle -> state=LOAD, `waddr`=0, `load_ready`=1, `instr_valid`=0, `start`=0; then stream 16 new beats -> the new image fetches correctly.
- Parity (`IFETCH_PARITY_EN` defined): force one data bit of `mem[6]` to flip, fetch 6 -> `parity_err`=1 and `instr_valid`=1. Fetch 7 -> `parity_err`=0. With the macro undefined, `parity_err` stays 0.

Source files
------------

// File: rtl/glorb_pkg.sv
// glorb_pkg: shared constants and types for instr_fetch.
// IFETCH_PARITY_EN selects one even-parity bit per stored word.
package glorb_pkg;
  localparam int IW_DEF = 8;
  localparam int IMW_DEF = 4;
`ifdef IFETCH_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  typedef enum logic [0:0] {LOAD = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/imem_bank.sv
// imem_bank: instruction store with synchronous write and registered read.
module imem_bank
  import glorb_pkg::*;
#(
  parameter int W = IW_DEF + PW,
  parameter int AW = IMW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: loadable instruction store answering program-counter fetches.
// Define IFETCH_PARITY_EN to store and check an even-parity bit per word.
module instr_fetch
  import glorb_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int IMW = IMW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [IW-1:0]  load_data,
  input  logic           load_last,
  input  logic           load_restart,
  output logic           start,
  input  logic [IMW-1:0] pc_in,
  input  logic           flush,
  output logic [IW-1:0]  instr,
  output logic           instr_valid,
  output logic           parity_err
);
  state_t state;
  logic [IMW-1:0] waddr;
  logic [IW+PW-1:0] wdata, rdata;
  logic accept, done, re;
  assign load_ready = state == LOAD;
  assign accept = load_ready && load_valid;
  assign done = accept && (load_last || &waddr);
  assign re = state == RUN && !load_restart;
  assign instr = rdata[IW-1:0];
`ifdef IFETCH_PARITY_EN
  assign wdata = {^load_data, load_data};
  // instr_valid is already low for flushed fetches, so it gates the check
  assign parity_err = instr_valid && ^rdata;
`else
  assign wdata = load_data;
  assign parity_err = 1'b0;
`endif
  imem_bank #(.W(IW + PW), .AW(IMW)) u_bank (
    .clk(clk), .rst_n(rst_n), .we(accept), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(pc_in), .rdata(rdata)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= LOAD;
      waddr <= '0;
      start <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      start <= done;
      if (state == LOAD) begin
        if (accept) waddr <= waddr + 1'b1;
        if (done) state <= RUN;
      end else if (load_restart) begin
        state <= LOAD;
        waddr <= '0;
        instr_valid <= 1'b0;
      end else instr_valid <= !flush;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
module tb_instr_fetch;
  logic clk = 0, rst_n = 0, load_valid = 0, load_last = 0, load_restart = 0, flush = 0;
  logic [7:0] load_data = '0;
  logic [3:0] pc_in = '0;
  logic load_ready, start, instr_valid, parity_err;
  logic [7:0] instr;
  int n_chk = 0, n_fail = 0;
  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .load_restart(load_restart),
    .start(start), .pc_in(pc_in), .flush(flush), .instr(instr),
    .instr_valid(instr_valid), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] d, input logic last);
    load_valid = 1;
    load_data = d;
    load_last = last;
    step();
    load_valid = 0;
    load_last = 0;
  endtask
  task automatic fetch(input logic [3:0] a, input logic [7:0] exp, input string tag);
    pc_in = a;
    step();
    chk({tag, "_instr"}, instr, exp);
    chk({tag, "_valid"}, instr_valid, 1);
    chk({tag, "_perr"}, parity_err, 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_ready", load_ready, 1);
    chk("rst_start", start, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_perr", parity_err, 0);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      beat(8'h10 + 8'(i), 0);
      chk("full_start", start, i == 15);
    end
    chk("full_ready", load_ready, 0);
    pc_in = 5;
    step();
    chk("start_once", start, 0);
    chk("f5_instr", instr, 8'h15);
    chk("f5_valid", instr_valid, 1);
    fetch(15, 8'h1F, "f15");
    fetch(0, 8'h10, "f0");
    pc_in = 4;
    flush = 1;
    step();
    flush = 0;
    chk("flush_valid", instr_valid, 0);
    chk("flush_perr", parity_err, 0);
    fetch(4, 8'h14, "after_flush");
    load_restart = 1;
    step();
    load_restart = 0;
    chk("restart_ready", load_ready, 1);
    chk("restart_valid", instr_valid, 0);
    beat(8'hA0, 0);
    beat(8'hA1, 0);
    chk("part_nostart", start, 0);
    beat(8'hA2, 1);
    chk("part_start", start, 1);
    chk("part_ready", load_ready, 0);
    pc_in = 2;
    step();
    chk("part_start_once", start, 0);
    chk("part_f2", instr, 8'hA2);
    fetch(3, 8'h13, "part_f3");
    fetch(0, 8'hA0, "part_f0");
    load_restart = 1;
    step();
    load_restart = 0;
    for (int i = 0; i < 7; i++) beat(8'h50 + 8'(i), 0);
    chk("mid_waddr_pre", dut.waddr, 7);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mid_state", dut.state, 0);
    chk("mid_waddr", dut.waddr, 0);
    chk("mid_ready", load_ready, 1);
    chk("mid_valid", instr_valid, 0);
    chk("mid_start", start, 0);
    for (int i = 0; i < 16; i++) beat(8'h30 + 8'(i), 0);
    chk("reload_start", start, 1);
    fetch(6, 8'h36, "re_f6");
    fetch(0, 8'h30, "re_f0");
    fetch(9, 8'h39, "re_f9");
`ifdef IFETCH_PARITY_EN
    dut.u_bank.mem[6] = dut.u_bank.mem[6] ^ 9'h001;
    pc_in = 6;
    step();
    chk("par_err6", parity_err, 1);
    chk("par_valid6", instr_valid, 1);
    fetch(7, 8'h37, "par_f7");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
